// File: rtl/pulse_stretcher_if.sv
// Bundle of the pulse_stretcher event/status signals.
//   pulse_in   : event pulse into the stretcher (driven by the master)
//   clr_ovf    : synchronous clear of the sticky overflow flag (master)
//   level_out  : stretched output level (slave)
//   busy       : stretcher not idle (slave)
//   done_pulse : one-cycle pulse in the first cycle after a window ends (slave)
//   pending    : number of queued pulses (slave)
//   overflow   : sticky flag, a pulse was dropped (slave)
//   state_dbg  : current FSM state, for observation only (slave)
// Handshake: there is no back-pressure. Every cycle with pulse_in=1 is one
// event; it either starts a window, joins the queue, or is dropped and
// recorded in overflow.
interface pulse_stretcher_if #(
  parameter int QUEUE_DEPTH = 3
);
  logic                             pulse_in;
  logic                             clr_ovf;
  logic                             level_out;
  logic                             busy;
  logic                             done_pulse;
  logic [$clog2(QUEUE_DEPTH+1)-1:0] pending;
  logic                             overflow;
  logic [1:0]                       state_dbg;

  modport master (
    output pulse_in, clr_ovf,
    input  level_out, busy, done_pulse, pending, overflow, state_dbg
  );

  modport slave (
    input  pulse_in, clr_ovf,
    output level_out, busy, done_pulse, pending, overflow, state_dbg
  );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed HOLD_CYCLES-long high
// windows, each followed by a GAP_CYCLES-long low gap. Pulses arriving while
// a window or gap is running are counted (up to QUEUE_DEPTH) and replayed.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pulse_stretcher_if slave (pulse_in, clr_ovf in; level_out, busy,
//           done_pulse, pending, overflow, state_dbg out; all outputs registered)
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int QUEUE_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pulse_stretcher_if.slave       bus
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = $clog2(QUEUE_DEPTH + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pending, pending_nxt;
  logic          overflow, overflow_nxt;
  logic          level_q, busy_q, done_q;
  logic          level_nxt, busy_nxt, done_nxt;

  logic          gap_last;
  logic          queue_inc;
  logic          drop;

  // State register: FSM state, down-counter, queue and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      level_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
      level_q  <= level_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  assign gap_last = (state == GAP) && (cnt == '0);

  // Next-state and counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.pulse_in) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if ((pending != '0) || bus.pulse_in) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Queue and overflow. On the last GAP cycle a pulse never increments:
  // with an empty queue it starts the next window itself, otherwise it
  // takes the slot freed by the replayed pulse (net zero).
  assign queue_inc = bus.pulse_in && ((state == HOLD) || ((state == GAP) && !gap_last));
  assign drop      = queue_inc && (pending == PEND_MAX);

  always_comb begin
    pending_nxt = pending;
    if (gap_last && (pending != '0)) begin
      if (!bus.pulse_in) pending_nxt = pending - 1'b1;
    end else if (queue_inc && !drop) begin
      pending_nxt = pending + 1'b1;
    end
  end

  // A drop on the same edge as clr_ovf keeps the flag set.
  always_comb begin
    overflow_nxt = overflow;
    if (drop)             overflow_nxt = 1'b1;
    else if (bus.clr_ovf) overflow_nxt = 1'b0;
  end

  // Output decode from the next state so outputs are registered yet aligned
  // with the state they describe.
  always_comb begin
    level_nxt = (state_nxt == HOLD);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state == HOLD) && (state_nxt == GAP);
  end

  assign bus.level_out  = level_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;
  assign bus.pending    = pending;
  assign bus.overflow   = overflow;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  pulse_stretcher_if #(.QUEUE_DEPTH(3)) a ();
  pulse_stretcher_if #(.QUEUE_DEPTH(3)) b ();

  pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .QUEUE_DEPTH(3)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .QUEUE_DEPTH(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    a.pulse_in = 1'b0;
    b.pulse_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    a.pulse_in = 1'b0;
    a.clr_ovf  = 1'b0;
    b.pulse_in = 1'b0;
    b.clr_ovf  = 1'b0;
    #12;
    vectors++;
    if ({a.level_out, a.busy, a.done_pulse, a.pending, a.overflow} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_a: got lvl=%b busy=%b done=%b pend=%0d ovf=%b, want all 0",
               a.level_out, a.busy, a.done_pulse, a.pending, a.overflow);
    end
    vectors++;
    if ({b.level_out, b.busy, b.done_pulse, b.pending, b.overflow} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_b: got lvl=%b busy=%b done=%b pend=%0d ovf=%b, want all 0",
               b.level_out, b.busy, b.done_pulse, b.pending, b.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    vectors++;
    if (a.busy !== 1'b0 || a.level_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got busy=%b lvl=%b, want 0 0", a.busy, a.level_out);
    end
  endtask

  // Single pulse at edge 0.
  task automatic test_single();
    logic [7:0] exp_level;
    logic [7:0] exp_busy;
    logic [7:0] exp_done;
    exp_level = 8'b0000_1111;
    exp_busy  = 8'b0011_1111;
    exp_done  = 8'b0001_0000;
    for (int e = 0; e < 8; e++) begin
      a.pulse_in = (e == 0);
      tick();
      vectors++;
      if (a.level_out !== exp_level[e] || a.busy !== exp_busy[e] ||
          a.done_pulse !== exp_done[e] || a.pending !== 2'd0) begin
        miscompares++;
        $display("FAIL single e%0d: got lvl=%b busy=%b done=%b pend=%0d, want %b %b %b 0",
                 e, a.level_out, a.busy, a.done_pulse, a.pending,
                 exp_level[e], exp_busy[e], exp_done[e]);
      end
    end
    a.pulse_in = 1'b0;
  endtask

  // Pulses at edges 0, 1, 2: two queued, replayed at edges 6 and 12.
  task automatic test_back_to_back();
    logic [1:0] exp_pend;
    logic       exp_lvl;
    for (int e = 0; e < 20; e++) begin
      a.pulse_in = (e <= 2);
      tick();
      exp_pend = (e == 0) ? 2'd0 : (e == 1) ? 2'd1 : (e < 6) ? 2'd2 : (e < 12) ? 2'd1 : 2'd0;
      exp_lvl  = (e <= 3) || (e >= 6 && e <= 9) || (e >= 12 && e <= 15);
      vectors++;
      if (a.pending !== exp_pend || a.level_out !== exp_lvl) begin
        miscompares++;
        $display("FAIL b2b e%0d: got pend=%0d lvl=%b, want pend=%0d lvl=%b",
                 e, a.pending, a.level_out, exp_pend, exp_lvl);
      end
      if (e == 17 || e == 18) begin
        vectors++;
        if (a.busy !== (e == 17)) begin
          miscompares++;
          $display("FAIL b2b_busy e%0d: got %b, want %b", e, a.busy, (e == 17));
        end
      end
    end
    a.pulse_in = 1'b0;
    vectors++;
    if (a.overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_ovf: got %b, want 0", a.overflow);
    end
  endtask

  // Pulse held for 10 edges: saturation, drop, set-wins, clear.
  task automatic test_saturate();
    for (int e = 0; e < 32; e++) begin
      a.pulse_in = (e <= 9);
      a.clr_ovf  = (e == 7) || (e == 20);
      tick();
      case (e)
        3: begin
          vectors++;
          if (a.pending !== 2'd3 || a.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_full e3: got pend=%0d ovf=%b, want 3 0", a.pending, a.overflow);
          end
        end
        4: begin
          vectors++;
          if (a.pending !== 2'd3 || a.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_drop e4: got pend=%0d ovf=%b, want 3 1", a.pending, a.overflow);
          end
        end
        6: begin
          vectors++;
          if (a.pending !== 2'd3 || a.level_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_netzero e6: got pend=%0d lvl=%b, want 3 1", a.pending, a.level_out);
          end
        end
        7: begin
          vectors++;
          if (a.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_setwins e7: got ovf=%b, want 1", a.overflow);
          end
        end
        12: begin
          vectors++;
          if (a.pending !== 2'd2) begin
            miscompares++;
            $display("FAIL sat_pend e12: got %0d, want 2", a.pending);
          end
        end
        19: begin
          vectors++;
          if (a.overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_sticky e19: got ovf=%b, want 1", a.overflow);
          end
        end
        20: begin
          vectors++;
          if (a.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_clr e20: got ovf=%b, want 0", a.overflow);
          end
        end
        24: begin
          vectors++;
          if (a.pending !== 2'd0 || a.level_out !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_last e24: got pend=%0d lvl=%b, want 0 1", a.pending, a.level_out);
          end
        end
        29, 30: begin
          vectors++;
          if (a.busy !== (e == 29)) begin
            miscompares++;
            $display("FAIL sat_busy e%0d: got %b, want %b", e, a.busy, (e == 29));
          end
        end
        default: ;
      endcase
    end
    a.pulse_in = 1'b0;
    a.clr_ovf  = 1'b0;
  endtask

  // Second pulse exactly on the last GAP cycle with an empty queue.
  task automatic test_gap_boundary();
    logic exp_lvl;
    for (int e = 0; e < 14; e++) begin
      a.pulse_in = (e == 0) || (e == 6);
      tick();
      exp_lvl = (e <= 3) || (e >= 6 && e <= 9);
      vectors++;
      if (a.level_out !== exp_lvl || a.pending !== 2'd0) begin
        miscompares++;
        $display("FAIL gap_edge e%0d: got lvl=%b pend=%0d, want %b 0",
                 e, a.level_out, a.pending, exp_lvl);
      end
      if (e == 12) begin
        vectors++;
        if (a.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL gap_edge_idle e12: got busy=%b, want 0", a.busy);
        end
      end
    end
    a.pulse_in = 1'b0;
  endtask

  // Asynchronous reset in the middle of a window with two queued pulses.
  task automatic test_reset_mid();
    for (int e = 0; e < 3; e++) begin
      a.pulse_in = 1'b1;
      tick();
    end
    a.pulse_in = 1'b0;
    vectors++;
    if (a.pending !== 2'd2 || a.level_out !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got pend=%0d lvl=%b, want 2 1", a.pending, a.level_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a.level_out !== 1'b0 || a.busy !== 1'b0 || a.pending !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got lvl=%b busy=%b pend=%0d, want 0 0 0",
               a.level_out, a.busy, a.pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (a.level_out !== 1'b0 || a.busy !== 1'b0 || a.pending !== 2'd0) begin
        miscompares++;
        $display("FAIL rst_mid_after c%0d: got lvl=%b busy=%b pend=%0d, want 0 0 0",
                 e, a.level_out, a.busy, a.pending);
      end
    end
  endtask

  // HOLD=1, GAP=1 instance: pulses at edges 0 and 1.
  task automatic test_short_window();
    logic [5:0] exp_level;
    logic [5:0] exp_done;
    exp_level = 6'b00_0101;
    exp_done  = 6'b00_1010;
    for (int e = 0; e < 6; e++) begin
      b.pulse_in = (e <= 1);
      tick();
      vectors++;
      if (b.level_out !== exp_level[e] || b.done_pulse !== exp_done[e]) begin
        miscompares++;
        $display("FAIL short e%0d: got lvl=%b done=%b, want %b %b",
                 e, b.level_out, b.done_pulse, exp_level[e], exp_done[e]);
      end
    end
    b.pulse_in = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    idle_cycles(2);
    test_back_to_back();
    idle_cycles(2);
    test_saturate();
    idle_cycles(2);
    test_gap_boundary();
    idle_cycles(2);
    test_reset_mid();
    idle_cycles(2);
    test_short_window();
    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
